// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Types and helpers shared by the iterative BCD-to-binary converter.
//   state_t    : controller state encoding (IDLE / CONV / DONE)
//   BCD_MAX    : largest legal BCD digit value
//   MAC_W      : working width of the shared multiply-by-ten helper
//   mul10_add  : acc*10 + digit built purely from shifts and adds
//   pow10      : constant function used for parameter range checks
// -----------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // The helper works at a fixed wide width; callers zero-extend their
    // accumulator in and truncate the result back to their own width.
    localparam int MAC_W = 64;

    // acc*10 + digit as (acc<<3) + (acc<<1) + digit, so no multiplier is inferred.
    function automatic logic [MAC_W-1:0] mul10_add(input logic [MAC_W-1:0] acc,
                                                   input logic [3:0]       digit);
        return (acc << 3) + (acc << 1) + {{(MAC_W-4){1'b0}}, digit};
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_mac.sv
// -----------------------------------------------------------------------------
// bcd_digit_mac
// Combinational single-digit step of the BCD-to-binary conversion.
//   acc_in    [OUT_W-1:0] : running binary value
//   digit     [3:0]       : next BCD digit (MSD first)
//   acc_out   [OUT_W-1:0] : acc_in*10 + digit, truncated to OUT_W
//   digit_bad             : digit is not a legal BCD value (> 9)
// -----------------------------------------------------------------------------
module bcd_digit_mac
    import bcd_pkg::*;
#(
    parameter int OUT_W = 10
) (
    input  logic [OUT_W-1:0] acc_in,
    input  logic [3:0]       digit,
    output logic [OUT_W-1:0] acc_out,
    output logic             digit_bad
);

    always_comb begin
        acc_out   = OUT_W'(mul10_add(MAC_W'(acc_in), digit));
        digit_bad = (digit > BCD_MAX);
    end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// -----------------------------------------------------------------------------
// bcd_to_bin_seq
// Iterative multi-operand BCD-to-binary converter. Operands are accepted one
// at a time and converted MSD-first at one digit per cycle; once all NOPS
// operands of a batch are done, the packed results and per-operand error
// flags are offered on a valid/ready output.
//   clk        : clock, rising edge
//   rst        : synchronous reset, active-low
//   abort      : synchronous batch abort, active-high
//   in_valid   : operand presented
//   in_ready   : converter idle and out of reset
//   in_bcd     : NDIG BCD digits, digit NDIG-1 is the MSD
//   out_valid  : batch results available
//   out_ready  : consumer takes the batch
//   out_bin    : NOPS results, operand k at [k*OUT_W +: OUT_W]
//   out_err    : bit k set when operand k held a digit > 9
//   busy       : converting or holding results
// -----------------------------------------------------------------------------
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int NDIG  = 3,
    parameter int NOPS  = 2,
    parameter int OUT_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*NDIG-1:0]     in_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NOPS*OUT_W-1:0] out_bin,
    output logic [NOPS-1:0]       out_err,
    output logic                  busy
);

    localparam int IN_W  = 4 * NDIG;
    localparam int IDX_W = (NOPS > 1) ? $clog2(NOPS) : 1;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NOPS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

    // Result width must hold the largest NDIG-digit decimal value.
    if (NDIG < 1 || NOPS < 1 || OUT_W < 1 || OUT_W > MAC_W || NDIG > 19 ||
        (OUT_W < 64 && (64'd1 << OUT_W) < pow10(NDIG))) begin : g_param_check
        $error("bcd_to_bin_seq: invalid parameters (need NDIG,NOPS>=1 and 2**OUT_W >= 10**NDIG)");
    end

    state_t                  state_q,   state_d;
    logic [IDX_W-1:0]        idx_q,     idx_d;
    logic [CNT_W-1:0]        cnt_q,     cnt_d;
    logic [OUT_W-1:0]        acc_q,     acc_d;
    logic [IN_W-1:0]         sr_q,      sr_d;
    logic                    bad_q,     bad_d;
    logic [NOPS*OUT_W-1:0]   out_bin_q, out_bin_d;
    logic [NOPS-1:0]         out_err_q, out_err_d;

    logic [3:0]              digit;
    logic [OUT_W-1:0]        acc_next;
    logic                    digit_bad;
    logic                    accept;

    // The current MSD always sits at the top of the shift register.
    assign digit = sr_q[IN_W-1 -: 4];

    bcd_digit_mac #(
        .OUT_W (OUT_W)
    ) u_mac (
        .acc_in    (acc_q),
        .digit     (digit),
        .acc_out   (acc_next),
        .digit_bad (digit_bad)
    );

    // Handshake flags decode registered state only; in_ready also drops
    // combinationally while reset is held.
    assign in_ready  = (state_q == IDLE) && rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == CONV) || (state_q == DONE);
    assign out_bin   = out_bin_q;
    assign out_err   = out_err_q;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        sr_d      = sr_q;
        bad_d     = bad_q;
        out_bin_d = out_bin_q;
        out_err_d = out_err_q;

        if (abort) begin
            // Abort wins over any transition, including a coinciding accept.
            state_d   = IDLE;
            idx_d     = '0;
            cnt_d     = '0;
            acc_d     = '0;
            bad_d     = 1'b0;
            out_bin_d = '0;
            out_err_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        sr_d    = in_bcd;
                        acc_d   = '0;
                        cnt_d   = '0;
                        bad_d   = 1'b0;
                        state_d = CONV;
                        // Previous batch results stay visible until a new batch starts.
                        if (idx_q == '0) begin
                            out_bin_d = '0;
                            out_err_d = '0;
                        end
                    end
                end

                CONV: begin
                    acc_d = acc_next;
                    bad_d = bad_q | digit_bad;
                    sr_d  = sr_q << 4;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        out_bin_d[int'(idx_q)*OUT_W +: OUT_W] = bad_d ? '0 : acc_next;
                        out_err_d[idx_q] = bad_d;
                        if (idx_q == IDX_LAST) begin
                            idx_d   = '0;
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = IDLE;
                        end
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            bad_q     <= 1'b0;
            out_bin_q <= '0;
            out_err_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            bad_q     <= bad_d;
            out_bin_q <= out_bin_d;
            out_err_q <= out_err_d;
        end
        // Operand shift register is pure data; it is always reloaded on accept.
        sr_q <= sr_d;
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// -----------------------------------------------------------------------------
// tb_bcd_to_bin_seq
// Self-checking bench for bcd_to_bin_seq (NDIG=3, NOPS=2, OUT_W=10).
// -----------------------------------------------------------------------------
module tb_bcd_to_bin_seq;

    localparam int NDIG  = 3;
    localparam int NOPS  = 2;
    localparam int OUT_W = 10;

    logic                  clk;
    logic                  rst;
    logic                  abort;
    logic                  in_valid;
    logic                  in_ready;
    logic [4*NDIG-1:0]     in_bcd;
    logic                  out_valid;
    logic                  out_ready;
    logic [NOPS*OUT_W-1:0] out_bin;
    logic [NOPS-1:0]       out_err;
    logic                  busy;

    bcd_to_bin_seq #(
        .NDIG  (NDIG),
        .NOPS  (NOPS),
        .OUT_W (OUT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_err   (out_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int n_batches = 0;

    typedef struct {
        logic [NOPS*OUT_W-1:0] bin;
        logic [NOPS-1:0]       err;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Positional reference: sum of digit * 10**position.
    task automatic model(input logic [4*NDIG-1:0] bcd, output logic [OUT_W-1:0] v,
                         output logic e);
        int sum;
        int w;
        logic [3:0] d;
        sum = 0;
        w   = 1;
        e   = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            d = bcd[4*i +: 4];
            if (d > 4'd9) e = 1'b1;
            sum += int'(d) * w;
            w   *= 10;
        end
        v = e ? '0 : OUT_W'(sum);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_op(input logic [4*NDIG-1:0] bcd, output int acc_cyc);
        int n;
        in_bcd   = bcd;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("accept_ready", in_ready, 1);
        tick();
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic send_batch(input logic [4*NDIG-1:0] a, input logic [4*NDIG-1:0] b,
                              output exp_t e);
        logic [OUT_W-1:0] v0, v1;
        logic             e0, e1;
        int               c0, c1;
        model(a, v0, e0);
        model(b, v1, e1);
        e.bin = {v1, v0};
        e.err = {e1, e0};
        sb.push_back(e);
        send_op(a, c0);
        send_op(b, c1);
        chk("batch_period", c1 - c0, NDIG + 1);
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        chk("out_valid_seen", out_valid, 1);
        tick();
    endtask

    // Scoreboard consumer: compare whenever the DUT hands over a batch.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            exp_t e;
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_bin", out_bin, e.bin);
                chk("out_err", out_err, e.err);
                n_batches++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   a0, a1;

        rst       = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_bcd    = '0;
        out_ready = 1'b1;
        tick(); tick(); tick();

        chk("rst_in_ready",  in_ready,  0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_bin",   out_bin,   0);
        chk("rst_out_err",   out_err,   0);
        chk("rst_busy",      busy,      0);
        rst = 1'b1;
        #1;
        chk("idle_in_ready", in_ready, 1);

        // Basic batch with exact latency check.
        e.bin = {10'd45, 10'd123};
        e.err = 2'b00;
        sb.push_back(e);
        send_op(12'h123, a0);
        chk("op0_in_ready_low", in_ready, 0);
        send_op(12'h045, a1);
        chk("batch_period0", a1 - a0, NDIG + 1);
        tick();
        tick();
        chk("ov_not_early", out_valid, 0);
        tick();
        chk("ov_at_latency", out_valid, 1);
        chk("busy_done", busy, 1);
        tick();
        chk("ov_dropped", out_valid, 0);
        chk("in_ready_back", in_ready, 1);

        // Max values, no truncation.
        send_batch(12'h999, 12'h000, e);
        wait_out();

        // Invalid digit in operand 0.
        send_batch(12'h1A3, 12'h007, e);
        wait_out();

        // Backpressure: results held while out_ready is low.
        out_ready = 1'b0;
        send_batch(12'h321, 12'h654, e);
        a0 = 0;
        while (!out_valid && a0 < 50) begin
            tick();
            a0++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_bin",   out_bin,   e.bin);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("hold_drop",     out_valid, 0);
        chk("hold_in_ready", in_ready,  1);
        chk("retain_bin",    out_bin,   {10'd654, 10'd321});

        // Abort in the second CONV cycle of operand 1.
        send_op(12'h111, a0);
        send_op(12'h222, a1);
        chk("slot0_pre_abort", out_bin[OUT_W-1:0], 111);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_in_ready",  in_ready,  1);
        chk("abort_out_bin",   out_bin,   0);
        chk("abort_out_err",   out_err,   0);
        chk("abort_out_valid", out_valid, 0);
        send_batch(12'h010, 12'h002, e);
        wait_out();

        // Reset mid-conversion, with a simultaneous abort.
        send_op(12'h555, a0);
        tick();
        rst   = 1'b0;
        abort = 1'b1;
        #1;
        chk("rst_hold_in_ready", in_ready, 0);
        tick();
        rst   = 1'b1;
        abort = 1'b0;
        #1;
        chk("mid_rst_out_bin",   out_bin,   0);
        chk("mid_rst_out_err",   out_err,   0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy",      busy,      0);
        chk("mid_rst_in_ready",  in_ready,  1);
        send_batch(12'h100, 12'h099, e);
        wait_out();

        tick();
        chk("sb_drained", sb.size(), 0);
        chk("batch_count", n_batches, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
- Parametrised, iterative BCD-to-binary converter for multi-digit operands.
- Accepts up to NOPS operands, one per valid/ready handshake, each NDIG BCD digits wide.
- Converts each operand MSD-first at one digit per cycle: acc = acc*10 + digit.
- Once all operands of a batch are converted, presents the packed binary results and per-operand error flags through a valid/ready output handshake.
- Successor to the fixed two-operand, two-digit decoder in the calculator input path.

Parameters:
- NDIG, 3, BCD digits per operand (>=1).
- NOPS, 2, operands per batch (>=1).
- OUT_W, 10, binary result width per operand. Must satisfy 2**OUT_W >= 10**NDIG; checked by an elaboration-time assertion.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-low.
- abort  in  1  synchronous batch abort, active-high.
- in_valid  in  1  operand presented.
- in_ready  out  1  block can accept an operand.
- in_bcd  in  4*NDIG  operand; digit i is in_bcd[4i+3:4i], and digit NDIG-1 is the MSD.
- out_valid  out  1  batch results available.
- out_ready  in  1  consumer accepts the batch.
- out_bin  out  NOPS*OUT_W  results; operand k is in slice [k*OUT_W +: OUT_W].
- out_err  out  NOPS  bit k set means operand k contained a digit > 9.
- busy  out  1  high in CONV or DONE.

Behaviour:
- Reset: while rst==0 at a clock edge, the following are cleared: state=IDLE, op index=0, digit count=0, acc=0, out_bin=0, out_err=0, out_valid=0. in_ready=0 while rst==0.
- States:
  - IDLE: in_ready=1.
  - CONV: in_ready=0.
  - DONE: in_ready=0, out_valid=1.
- in_ready == (state==IDLE && rst==1). out_valid == (state==DONE). Both are decoded from registered state only.
- IDLE: on in_valid && in_ready:
  - capture in_bcd into a shift register;
  - clear acc and the digit counter;
  - go to CONV.
  - If op index==0, clear out_err and out_bin in the same edge.
- CONV: each cycle consumes the current MSD.
  - acc <= (acc<<3)+(acc<<1)+digit, truncated to OUT_W.
  - A digit > 9 sets a sticky per-operand bad flag.
  - Shift the register left by 4.
  - After exactly NDIG CONV cycles, write slot[idx] = bad ? 0 : final acc and out_err[idx] = bad.
  - Then: if idx==NOPS-1, go to DONE with idx reset to 0; else increment idx and return to IDLE.
- Latency: operand accepted at edge k is written at edge k+NDIG.
  - Intermediate operands: in_ready high in the cycle after edge k+NDIG.
  - Last operand: out_valid high in the cycle after edge k+NDIG.
  - Minimum batch time: NOPS*(NDIG+1) cycles.
- DONE: out_bin and out_err are held stable while out_valid=1. On out_valid && out_ready, go to IDLE; out_bin and out_err are retained until the next batch's first accept.
- An invalid operand does not stop the batch; the remaining operands are still converted.
- abort has priority over every state transition. At that edge it clears:
  - state → IDLE;
  - idx=0, acc=0;
  - out_valid → 0 next cycle;
  - out_err=0, out_bin=0.
  - A handshake coinciding with abort is dropped.
- rst has priority over abort.
- in_valid while in_ready==0 is ignored; the producer holds data until accepted.
- NDIG=1: exactly one CONV cycle per operand.

Decomposition:
- Package bcd_pkg:
  - state enum {IDLE, CONV, DONE};
  - localparam BCD_MAX=4'd9;
  - function mul10_add(acc, digit), built from the shift-add form (no multiplier).
- Sub-module bcd_digit_mac (parameter OUT_W). Combinational: acc_in, digit → acc_out, digit_bad. Instanced once by the FSM datapath.

Test Plan:
- NDIG=3, NOPS=2, out_ready=1: send 0x123 then 0x045.
  - out_bin slot0=123, slot1=45, out_err=2'b00.
  - out_valid rises exactly 3 cycles after the second accept.
- Send 0x999 and 0x000.
  - slot0=999, slot1=0, out_err=0.
  - No truncation at OUT_W=10.
- Send 0x1A3 then 0x007.
  - slot0=0, slot1=7, out_err=2'b01.
  - Batch completes normally.
- Completed batch with out_ready held low 5 cycles.
  - out_valid and out_bin stay stable for all 5 cycles.
  - Drop one cycle after out_ready goes high.
  - in_ready returns the following cycle.
- Assert abort during the second CONV cycle of operand 1.
  - Next cycle: in_ready=1, out_err=0, out_bin=0.
  - A new batch 0x010, 0x002 yields 10 and 2.
- Drive rst=0 for one edge mid-CONV.
  - All outputs zero.
  - Simultaneous abort has no extra effect.
  - Conversion restarts cleanly from operand 0.
